mips_controller: RTL and testbench
==================================

Name: mips_controller

Overview:
- Main instruction decoder for the five-stage MIPS32 core.
- Decodes a 32-bit instruction word into datapath control signals: register destination, ALU source and op, memory access, write-back source, extension mode, LUI path, next-PC select, and JAL link.
- Outputs are registered: one pipeline stage, one-cycle latency.
- Feeds the ID/EX control path.

Parameters:
- None. Opcode, funct and control-code constants come from the shared package.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces every output to its NOP value.
- instr  input  32  instruction word; opcode = instr[31:26], funct = instr[5:0].
- regdst  output  1  1 = write-back register is rd; 0 = rt.
- alusrc  output  1  1 = ALU operand B is the extended immediate; 0 = rt.
- memtoreg  output  1  1 = write-back data is the memory load value.
- regwrite  output  1  GPR write enable.
- memwrite  output  1  data-memory store enable.
- memread  output  1  data-memory load enable.
- extop  output  1  1 = sign-extend imm16; 0 = zero-extend.
- luiop  output  1  1 = result is {imm16, 16'b0}.
- aluop  output  3  ALU op: 000 add, 001 sub, 010 or, 011 and, others reserved.
- npc_slc  output  3  next PC: 000 PC+4, 001 beq target, 010 j/jal target, 011 jr (rs), others reserved.
- jalop  output  1  1 = write PC+8 to $31.

Behaviour:
- Clocking and reset:
  - Single always block on posedge clk / posedge reset.
  - While reset is high, all outputs = 0 (NOP encoding). They stay 0 until the first rising edge after reset deasserts.
  - Reset asserted mid-stream clears outputs immediately, without waiting for a clock edge.
- Latency: outputs at edge N reflect the instr sampled at edge N. They hold until the next edge. There is no handshake.
- Decode table (every unlisted signal = 0):
  - addu (op 000000, funct 100001): regdst, regwrite; aluop 000.
  - subu (op 000000, funct 100011): regdst, regwrite; aluop 001.
  - jr (op 000000, funct 001000): npc_slc 011.
  - ori (001101): alusrc, regwrite; extop 0; aluop 010.
  - lw (100011): alusrc, memtoreg, regwrite, memread, extop; aluop 000.
  - sw (101011): alusrc, memwrite, extop; aluop 000.
  - beq (000100): extop; aluop 001; npc_slc 001.
  - lui (001111): alusrc, regwrite, luiop; aluop 000.
  - j (000010): npc_slc 010.
  - jal (000011): regwrite, jalop; npc_slc 010.
- Special cases:
  - instr = 0 (sll $0,$0,0 / nop) decodes to all-zero outputs.
  - Any other unsupported opcode/funct combination, including other R-type functs, decodes to all-zero outputs (treated as NOP, no side effects).
- Exclusivity: memwrite and memread are never both 1. regwrite = 0 whenever memwrite = 1.

Optional Feature:
- Macro: CTRL_ILLEGAL_INSTR_EN.
- When defined:
  - Adds output illegal (1 bit, registered, reset 0).
  - illegal = 1 for any instruction not in the decode table, except instr = 0.
  - All other outputs still decode as NOP.
- When undefined: the port does not exist and behaviour is otherwise identical.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_J, OP_JAL);
  - funct constants (FN_ADDU, FN_SUBU, FN_JR);
  - ALU op codes (ALU_ADD, ALU_SUB, ALU_OR, ALU_AND);
  - NPC select codes (NPC_PC4, NPC_BEQ, NPC_J, NPC_JR).
- Natural sub-module: mips_ctrl_decode, a purely combinational decode of instr into a control bundle. The top level registers that bundle.

Test Plan:
- Reset: assert reset with instr = 32'h3c01_1234 (lui) -> all outputs 0 immediately. After release and one edge -> regwrite = 1, alusrc = 1, luiop = 1.
- R-type: instr = 32'h0022_1821 (addu $3,$1,$2) -> regdst = 1, regwrite = 1, aluop = 000. Then 32'h0022_1823 (subu) -> aluop = 001.
- Memory: instr = 32'h8c22_0004 (lw) -> alusrc, memtoreg, regwrite, memread, extop = 1. Then 32'hac22_0004 (sw) -> alusrc, memwrite, extop = 1; regwrite = 0.
- Control flow:
  - 32'h1022_0003 (beq) -> npc_slc = 001, aluop = 001, extop = 1.
  - 32'h0800_0010 (j) -> npc_slc = 010.
  - 32'h0c00_0010 (jal) -> npc_slc = 010, jalop = 1, regwrite = 1.
  - 32'h03e0_0008 (jr $31) -> npc_slc = 011.
- Immediate and NOP: 32'h3422_00ff (ori) -> alusrc = 1, regwrite = 1, extop = 0, aluop = 010. instr = 0 -> all outputs 0.
- Illegal: 32'hfc00_0000 -> all outputs 0; with CTRL_ILLEGAL_INSTR_EN, illegal = 1 one edge later. It returns to 0 on the next legal instruction or on reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode, funct, ALU and next-PC constants plus the decoded control bundle.
// CTRL_ILLEGAL_INSTR_EN adds an illegal-instruction flag to the bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_J    = 3'b010;
    localparam logic [2:0] NPC_JR   = 3'b011;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       extop;
        logic       luiop;
        logic [2:0] aluop;
        logic [2:0] npc_slc;
        logic       jalop;
`ifdef CTRL_ILLEGAL_INSTR_EN
        logic       illegal;
`endif
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Purely combinational decode of a MIPS32 instruction word into a control bundle.
// CTRL_ILLEGAL_INSTR_EN flags unsupported encodings other than the all-zero nop.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_nop;

    assign w_op  = i_instr[31:26];
    assign w_fn  = i_instr[5:0];
    assign w_nop = (i_instr == 32'd0);

    always_comb begin
        o_ctrl = CTRL_NOP;
        unique case (w_op)
            OP_RTYPE: begin
                unique case (w_fn)
                    FN_ADDU: begin
                        o_ctrl.regdst   = 1'b1;
                        o_ctrl.regwrite = 1'b1;
                        o_ctrl.aluop    = ALU_ADD;
                    end
                    FN_SUBU: begin
                        o_ctrl.regdst   = 1'b1;
                        o_ctrl.regwrite = 1'b1;
                        o_ctrl.aluop    = ALU_SUB;
                    end
                    FN_JR: o_ctrl.npc_slc = NPC_JR;
                    default: begin
`ifdef CTRL_ILLEGAL_INSTR_EN
                        o_ctrl.illegal = 1'b1;
`endif
                    end
                endcase
            end
            OP_ORI: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.aluop    = ALU_OR;
            end
            OP_LW: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.memread  = 1'b1;
                o_ctrl.extop    = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
            end
            OP_SW: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memwrite = 1'b1;
                o_ctrl.extop    = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
            end
            OP_BEQ: begin
                o_ctrl.extop    = 1'b1;
                o_ctrl.aluop    = ALU_SUB;
                o_ctrl.npc_slc  = NPC_BEQ;
            end
            OP_LUI: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.luiop    = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
            end
            OP_J: o_ctrl.npc_slc = NPC_J;
            OP_JAL: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.jalop    = 1'b1;
                o_ctrl.npc_slc  = NPC_J;
            end
            default: begin
`ifdef CTRL_ILLEGAL_INSTR_EN
                o_ctrl.illegal = 1'b1;
`endif
            end
        endcase
        // sll $0,$0,0 is the canonical nop and must never be flagged
        if (w_nop) begin
            o_ctrl = CTRL_NOP;
        end
    end

endmodule

// File: rtl/mips_controller.sv
// Main instruction decoder: registers the decoded control bundle, one-cycle latency.
// CTRL_ILLEGAL_INSTR_EN adds the registered illegal output.
module mips_controller
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        regdst,
    output logic        alusrc,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        memwrite,
    output logic        memread,
    output logic        extop,
    output logic        luiop,
    output logic [2:0]  aluop,
    output logic [2:0]  npc_slc,
`ifdef CTRL_ILLEGAL_INSTR_EN
    output logic        illegal,
`endif
    output logic        jalop
);

    ctrl_t w_ctrl;
    ctrl_t r_ctrl;

    mips_ctrl_decode u_decode (
        .i_instr (instr),
        .o_ctrl  (w_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= CTRL_NOP;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign regdst   = r_ctrl.regdst;
    assign alusrc   = r_ctrl.alusrc;
    assign memtoreg = r_ctrl.memtoreg;
    assign regwrite = r_ctrl.regwrite;
    assign memwrite = r_ctrl.memwrite;
    assign memread  = r_ctrl.memread;
    assign extop    = r_ctrl.extop;
    assign luiop    = r_ctrl.luiop;
    assign aluop    = r_ctrl.aluop;
    assign npc_slc  = r_ctrl.npc_slc;
    assign jalop    = r_ctrl.jalop;
`ifdef CTRL_ILLEGAL_INSTR_EN
    assign illegal  = r_ctrl.illegal;
`endif

endmodule

// File: tb/tb_mips_controller.sv
// Table-driven bench for mips_controller plus reset and hold sequences.
// Define CTRL_ILLEGAL_INSTR_EN to also check the illegal output.
module tb_mips_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        regdst, alusrc, memtoreg, regwrite;
    logic        memwrite, memread, extop, luiop, jalop;
    logic [2:0]  aluop, npc_slc;
    logic        w_ill;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_controller dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .regdst   (regdst),
        .alusrc   (alusrc),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .memwrite (memwrite),
        .memread  (memread),
        .extop    (extop),
        .luiop    (luiop),
        .aluop    (aluop),
        .npc_slc  (npc_slc),
`ifdef CTRL_ILLEGAL_INSTR_EN
        .illegal  (w_ill),
`endif
        .jalop    (jalop)
    );

`ifndef CTRL_ILLEGAL_INSTR_EN
    assign w_ill = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [14:0] exp;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    // field order: regdst alusrc memtoreg regwrite memwrite memread extop luiop aluop npc jalop
    function automatic logic [14:0] mk(
        input logic rd, input logic as, input logic mr, input logic rw,
        input logic mw, input logic mrd, input logic ext, input logic lui,
        input logic [2:0] alu, input logic [2:0] npc, input logic jal);
        return {rd, as, mr, rw, mw, mrd, ext, lui, alu, npc, jal};
    endfunction

    function automatic logic [14:0] got();
        return {regdst, alusrc, memtoreg, regwrite, memwrite, memread,
                extop, luiop, aluop, npc_slc, jalop};
    endfunction

    task automatic check(input string name, input logic [14:0] exp, input logic ill);
        checks++;
        if (got() !== exp) begin
            failures++;
            $display("FAIL %s: ctrl got %b expected %b", name, got(), exp);
        end
`ifdef CTRL_ILLEGAL_INSTR_EN
        checks++;
        if (w_ill !== ill) begin
            failures++;
            $display("FAIL %s.illegal: got %b expected %b", name, w_ill, ill);
        end
`else
        if (ill === 1'bx) $display("unexpected x flag in %s", name);
`endif
        checks++;
        if ((memwrite && memread) || (memwrite && regwrite)) begin
            failures++;
            $display("FAIL %s.excl: mw=%b mr=%b rw=%b expected no overlap",
                     name, memwrite, memread, regwrite);
        end
    endtask

    logic [14:0] e_lui;
    logic [14:0] e_zero;
    logic [14:0] e_hold;

    initial begin
        e_zero = '0;
        e_lui  = mk(0,1,0,1,0,0,0,1,3'd0,3'd0,0);
        vecs[0]  = '{"addu",  32'h0022_1821, mk(1,0,0,1,0,0,0,0,3'd0,3'd0,0), 1'b0};
        vecs[1]  = '{"subu",  32'h0022_1823, mk(1,0,0,1,0,0,0,0,3'd1,3'd0,0), 1'b0};
        vecs[2]  = '{"lw",    32'h8c22_0004, mk(0,1,1,1,0,1,1,0,3'd0,3'd0,0), 1'b0};
        vecs[3]  = '{"sw",    32'hac22_0004, mk(0,1,0,0,1,0,1,0,3'd0,3'd0,0), 1'b0};
        vecs[4]  = '{"beq",   32'h1022_0003, mk(0,0,0,0,0,0,1,0,3'd1,3'd1,0), 1'b0};
        vecs[5]  = '{"j",     32'h0800_0010, mk(0,0,0,0,0,0,0,0,3'd0,3'd2,0), 1'b0};
        vecs[6]  = '{"jal",   32'h0c00_0010, mk(0,0,0,1,0,0,0,0,3'd0,3'd2,1), 1'b0};
        vecs[7]  = '{"jr",    32'h03e0_0008, mk(0,0,0,0,0,0,0,0,3'd0,3'd3,0), 1'b0};
        vecs[8]  = '{"ori",   32'h3422_00ff, mk(0,1,0,1,0,0,0,0,3'd2,3'd0,0), 1'b0};
        vecs[9]  = '{"nop",   32'h0000_0000, e_zero, 1'b0};
        vecs[10] = '{"badop", 32'hfc00_0000, e_zero, 1'b1};
        vecs[11] = '{"lui",   32'h3c01_1234, e_lui, 1'b0};
        vecs[12] = '{"add",   32'h0022_1820, e_zero, 1'b1};
        vecs[13] = '{"addu2", 32'h0022_1821, mk(1,0,0,1,0,0,0,0,3'd0,3'd0,0), 1'b0};
        vecs[14] = '{"sllnz", 32'h0001_1080, e_zero, 1'b1};

        reset = 1'b1;
        instr = 32'h3c01_1234;
        @(posedge clk); #1;
        check("rst_hold", e_zero, 1'b0);
        @(negedge clk);
        check("rst_noedge", e_zero, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_release", e_lui, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            instr = vecs[i].instr;
            #1;
            e_hold = got();
            checks++;
            if (i > 0 && e_hold !== vecs[i-1].exp) begin
                failures++;
                $display("FAIL %s.hold: got %b expected %b",
                         vecs[i].name, e_hold, vecs[i-1].exp);
            end
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp, vecs[i].ill);
        end

        // async reset mid-stream after an illegal instruction
        @(negedge clk);
        instr = 32'hfc00_0000;
        @(posedge clk); #1;
        check("ill_pre", e_zero, 1'b1);
        instr = 32'h8c22_0004;
        @(posedge clk); #1;
        check("lw_pre", vecs[2].exp, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("rst_async", e_zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        instr = 32'hfc00_0000;
        @(posedge clk); #1;
        check("ill_post", e_zero, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("rst_ill", e_zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        instr = 32'h3c01_1234;
        @(posedge clk); #1;
        check("lui_post", e_lui, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
